// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: one RV32 branch comparator shared round-robin by NUM_REQ requesters.
// Each granted compare lands in a single registered result slot with requester id, tag and error flag.
module cmp_share_arbiter #(
    parameter int  NUM_REQ = 2,
    parameter int  TAG_W   = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*3-1:0]     req_cmpop,
    input  logic [NUM_REQ*32-1:0]    req_a,
    input  logic [NUM_REQ*32-1:0]    req_b,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [TAG_W-1:0]         resp_tag,
    output logic                     resp_br_en,
    output logic                     resp_err
);

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Result packed as {err, br_en}; undefined encodings never report a taken branch.
    function automatic logic [1:0] cmp_eval(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [1:0] r;
        case (op)
            F3_BEQ:  r = {1'b0, a == b};
            F3_BNE:  r = {1'b0, a != b};
            F3_BLT:  r = {1'b0, $signed(a) <  $signed(b)};
            F3_BGE:  r = {1'b0, $signed(a) >= $signed(b)};
            F3_BLTU: r = {1'b0, a <  b};
            F3_BGEU: r = {1'b0, a >= b};
            default: r = 2'b10;
        endcase
        return r;
    endfunction

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               br_q, br_d;
    logic               err_q, err_d;

    logic               free_s;
    logic [NUM_REQ-1:0] gnt_s;
    logic               gnt_any_s;
    logic [ID_W-1:0]    gnt_idx_s;
    logic [2:0]         sel_op_s;
    logic [31:0]        sel_a_s;
    logic [31:0]        sel_b_s;
    logic [TAG_W-1:0]   sel_tag_s;
    logic [1:0]         cmp_s;
    logic [ID_W:0]      nxt_v;

    assign free_s = (state_q == ST_EMPTY) | resp_ready;

    // Round-robin search from rr_ptr, wrapping modulo NUM_REQ; first valid requester wins.
    always_comb begin
        logic [ID_W:0]   sum_v;
        logic [ID_W-1:0] idx_v;
        logic            hit_v;
        gnt_s     = '0;
        gnt_idx_s = '0;
        gnt_any_s = 1'b0;
        sum_v     = '0;
        idx_v     = '0;
        hit_v     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_v = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            idx_v = (sum_v >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum_v - (ID_W+1)'(NUM_REQ)) : sum_v[ID_W-1:0];
            hit_v = free_s & ~gnt_any_s & req_valid[idx_v];
            gnt_s[idx_v] = gnt_s[idx_v] | hit_v;
            gnt_idx_s    = hit_v ? idx_v : gnt_idx_s;
            gnt_any_s    = gnt_any_s | hit_v;
        end
    end

    // One-hot operand mux driven by the grant vector.
    always_comb begin
        sel_op_s  = '0;
        sel_a_s   = '0;
        sel_b_s   = '0;
        sel_tag_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_op_s  = sel_op_s  | (req_cmpop[i*3 +: 3]         & {3{gnt_s[i]}});
            sel_a_s   = sel_a_s   | (req_a[i*32 +: 32]           & {32{gnt_s[i]}});
            sel_b_s   = sel_b_s   | (req_b[i*32 +: 32]           & {32{gnt_s[i]}});
            sel_tag_s = sel_tag_s | (req_tag[i*TAG_W +: TAG_W]   & {TAG_W{gnt_s[i]}});
        end
    end

    assign cmp_s = cmp_eval(sel_op_s, sel_a_s, sel_b_s);
    assign nxt_v = {1'b0, gnt_idx_s} + (ID_W+1)'(1);

    // Pointer advances past the winner only on a grant.
    always_comb begin
        if (gnt_any_s) begin
            rr_ptr_d = (nxt_v >= (ID_W+1)'(NUM_REQ)) ? '0 : nxt_v[ID_W-1:0];
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Slot next-state: a grant always (re)loads, otherwise a drain empties it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (gnt_any_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (gnt_any_s) begin
                    state_d = ST_FULL;
                end else if (resp_ready) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Result payload is captured only on a grant and otherwise held, even while empty.
    always_comb begin
        if (gnt_any_s) begin
            id_d  = gnt_idx_s;
            tag_d = sel_tag_s;
            br_d  = cmp_s[0];
            err_d = cmp_s[1];
        end else begin
            id_d  = id_q;
            tag_d = tag_q;
            br_d  = br_q;
            err_d = err_q;
        end
    end

    // State, pointer and result slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            rr_ptr_q <= '0;
            id_q     <= '0;
            tag_q    <= '0;
            br_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            tag_q    <= tag_d;
            br_q     <= br_d;
            err_q    <= err_d;
        end
    end

    // Output decode from the registered slot.
    always_comb begin
        resp_valid = (state_q == ST_FULL);
        resp_id    = id_q;
        resp_tag   = tag_q;
        resp_br_en = br_q;
        resp_err   = err_q;
        req_ready  = gnt_s;
    end

endmodule
